// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port synchronous-read data memory between the core MEM stage
// (fixed priority) and a debug/loader port, with a starvation counter that forces one debug slot.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_busy,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_IDLE,
        OWN_CORE,
        OWN_DBG
    } owner_t;

    owner_t            owner_q, owner_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              gnt_dbg, gnt_core;

    assign gnt_dbg  = dbg_req & (~core_req | (starve_cnt_q == LIMIT));
    assign gnt_core = core_req & ~gnt_dbg;

    assign core_busy  = core_req & gnt_dbg;
    assign dbg_gnt    = gnt_dbg;
    assign core_rdata = mem_rdata;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_dbg) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (gnt_core) begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

    always_comb begin
        owner_d = OWN_IDLE;
        if (gnt_dbg) begin
            owner_d = OWN_DBG;
        end else if (gnt_core) begin
            owner_d = OWN_CORE;
        end
    end

    // Counts only cycles debug loses to the core; any grant or withdrawn request restarts it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (gnt_dbg || !dbg_req) begin
            starve_cnt_d = 4'd0;
        end else if (core_req && (starve_cnt_q < LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Read data is shown straight from memory in the rvalid cycle and then held in dbg_rdata_q.
    assign dbg_rvalid_d = gnt_dbg & ~dbg_we;
    assign dbg_rdata_d  = ((owner_q == OWN_DBG) && dbg_rvalid_q) ? mem_rdata : dbg_rdata_q;
    assign dbg_rvalid   = dbg_rvalid_q;
    assign dbg_rdata    = dbg_rdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= OWN_IDLE;
            starve_cnt_q <= 4'd0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a synchronous-read memory model behind the mem port.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_busy;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_gnt, dbg_rvalid;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_busy  (core_busy),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h04] = 32'hDEADBEEF;
        mem[8'h09] = 32'hCAFEF00D;

        rst = 1'b1;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        dbg_req = 0;  dbg_we = 0;  dbg_addr = 0;  dbg_wdata = 0;
        step(); step();
        rst = 1'b0;
        #4;
        chk("reset_rvalid", {31'b0, dbg_rvalid}, 32'd0);
        chk("reset_rdata", dbg_rdata, 32'd0);
        chk("reset_mem_en", {31'b0, mem_en}, 32'd0);
        chk("reset_busy", {31'b0, core_busy}, 32'd0);

        // 1: core-only read
        step();
        core_req = 1; core_we = 0; core_addr = 32'h10;
        #4;
        chk("t1_mem_en", {31'b0, mem_en}, 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_busy", {31'b0, core_busy}, 32'd0);
        step();
        core_req = 0;
        #4;
        chk("t1_core_rdata", core_rdata, 32'hDEADBEEF);
        chk("t1_idle_mem_en", {31'b0, mem_en}, 32'd0);

        // 2: debug-only write then read
        step();
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h1234;
        #4;
        chk("t2_wr_gnt", {31'b0, dbg_gnt}, 32'd1);
        chk("t2_wr_mem_we", {31'b0, mem_we}, 32'd1);
        chk("t2_wr_wdata", mem_wdata, 32'h1234);
        step();
        dbg_we = 0;
        #4;
        chk("t2_rd_gnt", {31'b0, dbg_gnt}, 32'd1);
        chk("t2_rd_rvalid_after_wr", {31'b0, dbg_rvalid}, 32'd0);
        step();
        dbg_req = 0;
        #4;
        chk("t2_rvalid", {31'b0, dbg_rvalid}, 32'd1);
        chk("t2_rdata", dbg_rdata, 32'h1234);
        step();
        #4;
        chk("t2_rvalid_pulse", {31'b0, dbg_rvalid}, 32'd0);
        chk("t2_rdata_hold", dbg_rdata, 32'h1234);

        // 3: contention, forced slot at cycle 4
        step();
        core_req = 1; core_we = 0; core_addr = 32'h10;
        dbg_req = 1;  dbg_we = 0;  dbg_addr = 32'h24;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) dbg_req = 0;
            #4;
            chk($sformatf("t3_gnt_c%0d", c), {31'b0, dbg_gnt}, (c == 4) ? 32'd1 : 32'd0);
            chk($sformatf("t3_busy_c%0d", c), {31'b0, core_busy}, (c == 4) ? 32'd1 : 32'd0);
            chk($sformatf("t3_addr_c%0d", c), mem_addr, (c == 4) ? 32'h24 : 32'h10);
            if (c == 5) begin
                chk("t3_rvalid", {31'b0, dbg_rvalid}, 32'd1);
                chk("t3_rdata", dbg_rdata, 32'hCAFEF00D);
            end
            step();
        end

        // 4: debug withdraws at cycle 2, needs four fresh lost cycles
        dbg_req = 1;
        for (int c = 0; c < 9; c++) begin
            dbg_req = (c == 2) ? 1'b0 : 1'b1;
            #4;
            chk($sformatf("t4_gnt_c%0d", c), {31'b0, dbg_gnt}, (c == 7) ? 32'd1 : 32'd0);
            if (c == 7) dbg_req = 0;
            step();
        end
        core_req = 0; dbg_req = 0;
        #4;
        chk("t4_rdata_before_rst", dbg_rdata, 32'hCAFEF00D);

        // 5a: reset asserted in the cycle of a debug read grant
        step();
        rst = 1; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
        #4;
        chk("t5_gnt_in_rst", {31'b0, dbg_gnt}, 32'd1);
        step();
        rst = 0; dbg_req = 0;
        #4;
        chk("t5_rvalid", {31'b0, dbg_rvalid}, 32'd0);
        chk("t5_rdata", dbg_rdata, 32'd0);

        // 5b: counter built to 2, contended reset cycle, then four fresh lost cycles
        step();
        core_req = 1; dbg_req = 1; dbg_addr = 32'h24;
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        for (int c = 0; c < 5; c++) begin
            #4;
            chk($sformatf("t5_gnt_c%0d", c), {31'b0, dbg_gnt}, (c == 4) ? 32'd1 : 32'd0);
            step();
        end
        core_req = 0; dbg_req = 0;
        step();

        // 6: forced debug store then core load of same address
        core_req = 1; core_we = 0; core_addr = 32'h40;
        dbg_req = 1;  dbg_we = 1;  dbg_addr = 32'h40; dbg_wdata = 32'hA5A5A5A5;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) dbg_req = 0;
            #4;
            if (c == 4) begin
                chk("t6_forced_gnt", {31'b0, dbg_gnt}, 32'd1);
                chk("t6_forced_we", {31'b0, mem_we}, 32'd1);
            end
            if (c == 5) chk("t6_core_gnt", {31'b0, core_busy | dbg_gnt}, 32'd0);
            step();
        end
        core_req = 0;
        #4;
        chk("t6_core_rdata", core_rdata, 32'hA5A5A5A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
